// File: rtl/add_operand_pairer_pkg.sv
// Shared types and defaults for the adder operand pairer: FSM state enum, default geometry,
// and the FIFO occupancy-counter width helper.
package add_pairer_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADD_LAT = 2;
    localparam int DEF_DEPTH   = 4;

    typedef enum logic {
        EMPTY  = 1'b0,
        HAVE_X = 1'b1
    } pair_state_e;

    // Counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/add_operand_pairer_if.sv
// Signal bundle between stream source, pairer, adder and sink.
// The slave modport is the pairer side; the master modport is its environment.
interface add_operand_pairer_if
    import add_pairer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic [DATA_W-1:0] add_sum;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, add_sum, out_ready,
        output in_ready, add_x, add_y, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, add_sum, out_ready,
        input  in_ready, add_x, add_y, out_data, out_valid
    );
endinterface

// File: rtl/add_operand_pairer_fifo.sv
// Order-preserving register-array FIFO; head visible combinationally from storage, push lands next cycle.
// No internal backpressure: the caller guarantees a slot for every push, and push+pop when full is legal.
module add_pairer_fifo
    import add_pairer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [DATA_W-1:0]          push_dat,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_dat,
    output logic [cnt_w(DEPTH)-1:0]    count
);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push_vld) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_vld && !pop && count_q == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count_q == '0));

endmodule

// File: rtl/add_operand_pairer.sv
// Pairs stream words into (x,y) for a non-stallable ADD_LAT adder; sum appears on out_* ADD_LAT+2 cycles after the 2nd word.
// in_ready on the pairing word waits for a reserved FIFO slot (credit); ADD_PAIRER_COUNT_EN adds pair_count.
module add_operand_pairer
    import add_pairer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    add_operand_pairer_if.slave bus
`ifdef ADD_PAIRER_COUNT_EN
    ,
    output logic [15:0]         pair_count
`endif
);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int OUT_W = $clog2(DEPTH + ADD_LAT + 2);

    pair_state_e       state_q, state_d;
    logic [DATA_W-1:0] x_hold_q, x_hold_d;
    logic [DATA_W-1:0] add_x_q, add_x_d;
    logic [DATA_W-1:0] add_y_q, add_y_d;
    logic              issue_q, issue_d;
    logic [ADD_LAT-1:0] vpipe_q, vpipe_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [OUT_W-1:0]  outstanding;
    logic [DATA_W-1:0] head_dat;
    logic              credit_ok;
    logic              in_rdy;
    logic              accept;
    logic              push;
    logic              pop;
    logic              out_vld;

    // Every sum already committed (queued, issuing, or inside the adder) holds a slot.
    always_comb begin
        outstanding = OUT_W'(fifo_count) + OUT_W'(issue_q);
        for (int i = 0; i < ADD_LAT; i++) begin
            outstanding = outstanding + OUT_W'(vpipe_q[i]);
        end
    end

    assign credit_ok = outstanding < OUT_W'(DEPTH);
    assign in_rdy    = rst_n & ((state_q == EMPTY) | credit_ok);
    assign accept    = bus.in_valid & in_rdy;

    always_comb begin
        state_d  = state_q;
        x_hold_d = x_hold_q;
        add_x_d  = add_x_q;
        add_y_d  = add_y_q;
        issue_d  = 1'b0;
        if (accept) begin
            case (state_q)
                EMPTY: begin
                    x_hold_d = bus.in_data;
                    state_d  = HAVE_X;
                end
                HAVE_X: begin
                    add_x_d = x_hold_q;
                    add_y_d = bus.in_data;
                    issue_d = 1'b1;
                    state_d = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
        vpipe_d = (vpipe_q << 1) | ADD_LAT'(issue_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            x_hold_q <= '0;
            add_x_q  <= '0;
            add_y_q  <= '0;
            issue_q  <= 1'b0;
            vpipe_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_hold_q <= x_hold_d;
            add_x_q  <= add_x_d;
            add_y_q  <= add_y_d;
            issue_q  <= issue_d;
            vpipe_q  <= vpipe_d;
        end
    end

    // The pipe tail marks the cycle add_sum carries the sum of a live pair.
    assign push    = vpipe_q[ADD_LAT-1];
    assign out_vld = (fifo_count != '0);
    assign pop     = out_vld & bus.out_ready;

    add_pairer_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (bus.add_sum),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign bus.in_ready  = in_rdy;
    assign bus.add_x     = add_x_q;
    assign bus.add_y     = add_y_q;
    assign bus.out_data  = head_dat;
    assign bus.out_valid = out_vld;

`ifdef ADD_PAIRER_COUNT_EN
    logic [15:0] pair_count_q, pair_count_d;

    assign pair_count_d = pair_count_q + 16'(issue_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_count_q <= '0;
        end else begin
            pair_count_q <= pair_count_d;
        end
    end

    assign pair_count = pair_count_q;
`endif

endmodule
